// File: rtl/id_decode_stage.sv
// Instruction-decode stage: IF/ID pipeline register, 32x32 register file
// with same-cycle write-back bypass, main control decoder and load-use
// hazard detection feeding the ID/EX register.
module id_decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    output logic [9:0]  out_ctl,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic [31:0] out_rd1,
    output logic [31:0] out_rd2,
    output logic        stall
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_J     = 6'b000010
    } opcode_e;

    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] gpr [32];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [9:0]  ctl;
    logic        uses_rt;

    assign opcode = ifid_instr[31:26];
    assign rs     = ifid_instr[25:21];
    assign rt     = ifid_instr[20:16];

    // IF/ID register: reset and flush squash to NOP, stall holds, else load
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
        end else if (!stall) begin
            ifid_instr <= in_instr;
            ifid_pc    <= in_pc;
        end
    end

    // Register file write port; $0 is never written so it always reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_regwrite && (wb_addr != '0)) begin
            gpr[wb_addr] <= wb_data;
        end
    end

    // Read ports with write-back bypass so a same-cycle write is visible
    always_comb begin
        out_rd1 = gpr[rs];
        if (rs == '0) begin
            out_rd1 = '0;
        end else if (wb_regwrite && (wb_addr == rs)) begin
            out_rd1 = wb_data;
        end
        out_rd2 = gpr[rt];
        if (rt == '0) begin
            out_rd2 = '0;
        end else if (wb_regwrite && (wb_addr == rt)) begin
            out_rd2 = wb_data;
        end
    end

    // Main control decoder; uses_rt marks opcodes that read rt as a source
    always_comb begin
        ctl     = '0;
        uses_rt = 1'b0;
        case (opcode_e'(opcode))
            OP_RTYPE: begin
                ctl     = 10'b1_0_10_0_0_0_1_0_0;
                uses_rt = 1'b1;
            end
            OP_LW:   ctl = 10'b0_1_00_0_1_0_1_1_0;
            OP_SW: begin
                ctl     = 10'b0_1_00_0_0_1_0_0_0;
                uses_rt = 1'b1;
            end
            OP_BEQ: begin
                ctl     = 10'b0_0_01_1_0_0_0_0_0;
                uses_rt = 1'b1;
            end
            OP_ADDI: ctl = 10'b0_1_00_0_0_0_1_0_0;
            OP_J:    ctl = 10'b0_0_00_0_0_0_0_0_1;
            default: ctl = '0;
        endcase
    end

    // Load-use hazard: a pending load's destination is a source of this instruction
    always_comb begin
        stall = ex_memread && (ex_rt != '0) &&
                ((ex_rt == rs) || ((ex_rt == rt) && uses_rt));
    end

    // Bubble injection: control zeroed while stalled, data fields pass through
    always_comb begin
        out_ctl = stall ? '0 : ctl;
        out_rt  = rt;
        out_rd  = ifid_instr[15:11];
        out_imm = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
        out_pc  = ifid_pc;
    end

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed scenarios plus random traffic checked
// against an instruction-level reference model of the decode stage.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        wb_regwrite = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ex_memread = 1'b0;
    logic [4:0]  ex_rt = '0;
    logic [9:0]  out_ctl;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [31:0] out_rd1;
    logic [31:0] out_rd2;
    logic        stall;

    int total = 0;
    int bad = 0;

    id_decode_stage #(.NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .wb_regwrite(wb_regwrite), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .out_ctl(out_ctl), .out_rt(out_rt),
        .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc), .out_rd1(out_rd1),
        .out_rd2(out_rd2), .stall(stall)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc = '0;

    function automatic logic [9:0] pack_ctl(bit regdst, bit alusrc, bit [1:0] aluop, bit branch,
                                            bit memread, bit memwrite, bit regwrite,
                                            bit memtoreg, bit jump);
        return {regdst, alusrc, aluop, branch, memread, memwrite, regwrite, memtoreg, jump};
    endfunction

    function automatic logic [9:0] m_decode(logic [5:0] op);
        if (op == 6'd0)  return pack_ctl(1, 0, 2'b10, 0, 0, 0, 1, 0, 0);
        if (op == 6'd35) return pack_ctl(0, 1, 2'b00, 0, 1, 0, 1, 1, 0);
        if (op == 6'd43) return pack_ctl(0, 1, 2'b00, 0, 0, 1, 0, 0, 0);
        if (op == 6'd4)  return pack_ctl(0, 0, 2'b01, 1, 0, 0, 0, 0, 0);
        if (op == 6'd8)  return pack_ctl(0, 1, 2'b00, 0, 0, 0, 1, 0, 0);
        if (op == 6'd2)  return pack_ctl(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        return 10'd0;
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_regwrite && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_stall();
        logic [5:0] op;
        logic [4:0] s;
        logic [4:0] t;
        bit reads_t;
        op = m_instr[31:26];
        s = m_instr[25:21];
        t = m_instr[20:16];
        reads_t = (op == 6'd0) || (op == 6'd43) || (op == 6'd4);
        return ex_memread && ex_rt != 5'd0 && (ex_rt == s || (reads_t && ex_rt == t));
    endfunction

    function automatic logic [9:0] e_ctl();
        return m_stall() ? 10'd0 : m_decode(m_instr[31:26]);
    endfunction

    function automatic logic [31:0] e_imm();
        logic [15:0] lo;
        lo = m_instr[15:0];
        return 32'($signed(lo));
    endfunction

    // Advance one clock: model updates from pre-edge state, outputs sampled 1 time unit later
    task automatic cycle();
        bit st;
        st = m_stall();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_instr = 32'd0;
            m_pc = 32'd0;
        end else begin
            if (wb_regwrite && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
            if (flush) begin
                m_instr = 32'd0;
                m_pc = 32'd0;
            end else if (!st) begin
                m_instr = in_instr;
                m_pc = in_pc;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] r_instr(logic [4:0] s, logic [4:0] t, logic [4:0] d, logic [5:0] fn);
        return {6'd0, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_instr(logic [5:0] op, logic [4:0] s, logic [4:0] t, logic [15:0] im);
        return {op, s, t, im};
    endfunction

    localparam logic [9:0] CTL_R  = 10'b1010000100;
    localparam logic [9:0] CTL_LW = 10'b0100010110;

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_instr = 32'hFFFF_FFFF; in_pc = 32'h100;
        cycle();
        rst = 1'b0; in_instr = '0; in_pc = '0;
        total++; if (out_ctl !== CTL_R) begin bad++; $display("FAIL reset_ctl got=%h exp=%h", out_ctl, CTL_R); end
        total++; if (out_rd1 !== 32'd0 || out_rd2 !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h/%h exp=0", out_rd1, out_rd2); end
        total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (out_imm !== 32'd0 || out_rt !== 5'd0 || out_rd !== 5'd0) begin bad++; $display("FAIL reset_fields got=%h %h %h exp=0", out_imm, out_rt, out_rd); end
    endtask

    task automatic test_bypass();
        in_instr = r_instr(5'd5, 5'd0, 5'd3, 6'h20); in_pc = 32'h0000_0040;
        cycle();
        wb_regwrite = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        total++; if (out_rd1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_rd1 got=%h exp=%h", out_rd1, 32'hDEAD_BEEF); end
        total++; if (out_pc !== 32'h40) begin bad++; $display("FAIL bypass_pc got=%h exp=%h", out_pc, 32'h40); end
        cycle();
        wb_regwrite = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        #1;
        total++; if (out_rd1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL stored_rd1 got=%h exp=%h", out_rd1, 32'hDEAD_BEEF); end
        total++; if (out_rd2 !== 32'd0) begin bad++; $display("FAIL zero_bypass got=%h exp=0", out_rd2); end
        cycle();
        wb_regwrite = 1'b0;
        #1;
        total++; if (out_rd2 !== 32'd0) begin bad++; $display("FAIL zero_reg got=%h exp=0", out_rd2); end
    endtask

    task automatic test_lw_imm();
        in_instr = i_instr(6'd35, 5'd2, 5'd8, 16'hFFFC); in_pc = 32'h44;
        cycle();
        total++; if (out_imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL lw_imm got=%h exp=%h", out_imm, 32'hFFFF_FFFC); end
        total++; if (out_ctl !== CTL_LW) begin bad++; $display("FAIL lw_ctl got=%b exp=%b", out_ctl, CTL_LW); end
        total++; if (out_rt !== 5'd8) begin bad++; $display("FAIL lw_rt got=%0d exp=8", out_rt); end
        total++; if (out_pc !== 32'h44) begin bad++; $display("FAIL lw_pc got=%h exp=44", out_pc); end
    endtask

    task automatic test_load_use();
        in_instr = r_instr(5'd8, 5'd1, 5'd9, 6'h20); in_pc = 32'h48;
        cycle();
        ex_memread = 1'b1; ex_rt = 5'd8;
        in_instr = 32'hABCD_0000; in_pc = 32'h4C;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
        total++; if (out_ctl !== 10'd0) begin bad++; $display("FAIL lu_bubble got=%b exp=0", out_ctl); end
        cycle();
        total++; if (out_pc !== 32'h48 || out_rd !== 5'd9) begin bad++; $display("FAIL lu_hold got=pc %h rd %0d exp=pc 48 rd 9", out_pc, out_rd); end
        ex_memread = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall); end
        total++; if (out_ctl !== CTL_R) begin bad++; $display("FAIL lu_ctl got=%b exp=%b", out_ctl, CTL_R); end
        cycle();
        total++; if (out_pc !== 32'h4C) begin bad++; $display("FAIL lu_advance got=%h exp=4c", out_pc); end
    endtask

    task automatic test_no_hazard();
        in_instr = i_instr(6'd8, 5'd1, 5'd9, 16'd5); in_pc = 32'h50;
        cycle();
        ex_memread = 1'b1; ex_rt = 5'd9;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL addi_rt_dest got=%b exp=0", stall); end
        ex_rt = 5'd8;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL addi_other got=%b exp=0", stall); end
        in_instr = i_instr(6'd8, 5'd0, 5'd0, 16'd7);
        cycle();
        ex_rt = 5'd0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ex_rt_zero got=%b exp=0", stall); end
        ex_rt = 5'd1;
        in_instr = i_instr(6'd43, 5'd2, 5'd1, 16'd0);
        cycle();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sw_rt_hazard got=%b exp=1", stall); end
        ex_memread = 1'b0;
        cycle();
    endtask

    task automatic test_flush_stall();
        in_instr = r_instr(5'd8, 5'd1, 5'd9, 6'h20); in_pc = 32'h60;
        cycle();
        ex_memread = 1'b1; ex_rt = 5'd8; flush = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL fs_pre_stall got=%b exp=1", stall); end
        cycle();
        flush = 1'b0;
        #1;
        total++; if (out_pc !== 32'd0 || stall !== 1'b0 || out_ctl !== CTL_R) begin bad++; $display("FAIL fs_nop got=pc %h st %b ctl %b exp=pc 0 st 0 ctl %b", out_pc, stall, out_ctl, CTL_R); end
        in_instr = r_instr(5'd8, 5'd1, 5'd9, 6'h20); in_pc = 32'h64;
        cycle();
        rst = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rs_pre_stall got=%b exp=1", stall); end
        cycle();
        rst = 1'b0;
        #1;
        total++; if (stall !== 1'b0 || out_pc !== 32'd0) begin bad++; $display("FAIL rst_mid_stall got=st %b pc %h exp=st 0 pc 0", stall, out_pc); end
        ex_memread = 1'b0; ex_rt = 5'd0;
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd63};
        for (int n = 0; n < 400; n++) begin
            in_instr = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        16'($urandom)};
            in_pc = $urandom;
            flush = ($urandom_range(0, 9) == 0);
            wb_regwrite = $urandom_range(0, 1) == 1;
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            ex_memread = $urandom_range(0, 1) == 1;
            ex_rt = 5'($urandom_range(0, 7));
            #1;
            total++; if (stall !== m_stall()) begin bad++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall, m_stall()); end
            total++; if (out_ctl !== e_ctl()) begin bad++; $display("FAIL rand_ctl n=%0d got=%b exp=%b", n, out_ctl, e_ctl()); end
            total++; if (out_rd1 !== m_read(m_instr[25:21])) begin bad++; $display("FAIL rand_rd1 n=%0d got=%h exp=%h", n, out_rd1, m_read(m_instr[25:21])); end
            total++; if (out_rd2 !== m_read(m_instr[20:16])) begin bad++; $display("FAIL rand_rd2 n=%0d got=%h exp=%h", n, out_rd2, m_read(m_instr[20:16])); end
            total++; if (out_imm !== e_imm()) begin bad++; $display("FAIL rand_imm n=%0d got=%h exp=%h", n, out_imm, e_imm()); end
            total++; if (out_pc !== m_pc) begin bad++; $display("FAIL rand_pc n=%0d got=%h exp=%h", n, out_pc, m_pc); end
            total++; if (out_rt !== m_instr[20:16] || out_rd !== m_instr[15:11]) begin bad++; $display("FAIL rand_regs n=%0d got=%0d/%0d exp=%0d/%0d", n, out_rt, out_rd, m_instr[20:16], m_instr[15:11]); end
            cycle();
        end
        flush = 1'b0; wb_regwrite = 1'b0; ex_memread = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        #2;
        test_reset();
        test_bypass();
        test_lw_imm();
        test_load_use();
        test_no_hazard();
        test_flush_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
